reg_file: RTL and testbench

//   MIPS general-purpose register file: 32 x 32-bit, two combinational read ports, one write port.
//   - Write side is driven by the writeback stage outputs (regwrite_flag, write_data) plus the

---
 rtl/cmips_pkg.sv | 14 +
 rtl/reg_file_if.sv | 28 ++
 rtl/reg_file_clear_ctrl.sv | 49 ++++
 rtl/reg_file.sv | 69 ++++++
 tb/tb_reg_file.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/cmips_pkg.sv
// Shared constants and types for the cmips register file.
package cmips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_t;

endpackage

// File: rtl/reg_file_if.sv
// Register file port bundle: writeback write side, decode read side and ready.
interface reg_file_if
  import cmips_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) ();

  logic              regwrite_flag;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] read_addr_a;
  logic [ADDR_W-1:0] read_addr_b;
  logic [DATA_W-1:0] read_data_a;
  logic [DATA_W-1:0] read_data_b;
  logic              ready;

  modport master (
    output regwrite_flag, write_addr, write_data, read_addr_a, read_addr_b,
    input  read_data_a, read_data_b, ready
  );

  modport slave (
    input  regwrite_flag, write_addr, write_data, read_addr_a, read_addr_b,
    output read_data_a, read_data_b, ready
  );

endinterface

// File: rtl/reg_file_clear_ctrl.sv
// Post-reset clear sweep: walks every register index once, writing zero, then raises ready.
module reg_file_clear_ctrl
  import cmips_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_ready
);

  // One extra index bit so the end of the sweep never wraps back to entry 0.
  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

  rf_state_t       r_state;
  logic [ADDR_W:0] r_clearIdx;
  logic            r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RF_CLEAR;
      r_clearIdx <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        RF_CLEAR: begin
          r_clearIdx <= r_clearIdx + 1'b1;
          if (r_clearIdx == LAST_IDX) begin
            r_state <= RF_READY;
            r_ready <= 1'b1;
          end
        end
        RF_READY: r_ready <= 1'b1;
        default: begin
          r_state    <= RF_CLEAR;
          r_clearIdx <= '0;
          r_ready    <= 1'b0;
        end
      endcase
    end
  end

  assign o_clr_we   = (r_state == RF_CLEAR) && !rst;
  assign o_clr_addr = r_clearIdx[ADDR_W-1:0];
  assign o_ready    = r_ready;

endmodule

// File: rtl/reg_file.sv
// MIPS 32x32 register file, two combinational read ports, one write port, zeroing sweep after reset.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback value onto the read ports.
module reg_file
  import cmips_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input logic        clk,
  input logic        rst,
  reg_file_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_clrWe;
  logic [ADDR_W-1:0] w_clrAddr;
  logic              w_ready;
  logic              w_wbWe;
  logic [DATA_W-1:0] w_rdA;
  logic [DATA_W-1:0] w_rdB;

  reg_file_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk        (clk),
    .rst        (rst),
    .o_clr_we   (w_clrWe),
    .o_clr_addr (w_clrAddr),
    .o_ready    (w_ready)
  );

  assign w_wbWe = w_ready && !rst && bus.regwrite_flag && (bus.write_addr != '0);

  // Storage has no reset; the sweep owns the write port until ready, so writebacks are dropped then.
  always_ff @(posedge clk) begin
    if (w_clrWe) begin
      r_mem[w_clrAddr] <= '0;
    end else if (w_wbWe) begin
      r_mem[bus.write_addr] <= bus.write_data;
    end
  end

  always_comb begin
    w_rdA = '0;
    w_rdB = '0;
    if (w_ready) begin
      if (bus.read_addr_a != '0) begin
        w_rdA = r_mem[bus.read_addr_a];
`ifdef REGFILE_BYPASS_EN
        if (w_wbWe && (bus.write_addr == bus.read_addr_a)) w_rdA = bus.write_data;
`endif
      end
      if (bus.read_addr_b != '0) begin
        w_rdB = r_mem[bus.read_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (w_wbWe && (bus.write_addr == bus.read_addr_b)) w_rdB = bus.write_data;
`endif
      end
    end
  end

  assign bus.read_data_a = w_rdA;
  assign bus.read_data_b = w_rdB;
  assign bus.ready       = w_ready;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations follow REGFILE_BYPASS_EN when defined.
module tb_reg_file;
  import cmips_pkg::*;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;

  reg_file_if #(.DATA_W(REG_DATA_W), .ADDR_W(REG_ADDR_W)) bus ();

  reg_file #(
    .DATA_W (REG_DATA_W),
    .ADDR_W (REG_ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] ra, input logic [4:0] rb);
    bus.regwrite_flag = we;
    bus.write_addr    = wa;
    bus.write_data    = wd;
    bus.read_addr_a   = ra;
    bus.read_addr_b   = rb;
    #1;
  endtask

  task automatic checkReady(input string name, input logic exp);
    checkCount++;
    if (bus.ready !== exp)
      $display("[TB] FAIL %s: ready=%b expected %b", name, bus.ready, exp);
    else passCount++;
  endtask

  task automatic checkReads(input string name, input logic [31:0] expA, input logic [31:0] expB);
    checkCount++;
    if (bus.read_data_a !== expA || bus.read_data_b !== expB)
      $display("[TB] FAIL %s: a=%h b=%h expected a=%h b=%h",
               name, bus.read_data_a, bus.read_data_b, expA, expB);
    else passCount++;
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd9);
    rst = 1'b1;
    step();
    checkReady("reset_ready", 1'b0);
    checkReads("reset_reads", 32'h0, 32'h0);
    step();
    rst = 1'b0;
  endtask

  task automatic test_clear_sweep();
    bit lowOk;
    lowOk = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      #1;
      if (bus.ready !== 1'b0) begin
        lowOk = 1'b0;
        $display("[TB] FAIL sweep_low: ready=%b expected 0 at cycle %0d", bus.ready, i);
      end
      step();
    end
    checkCount++;
    if (lowOk) passCount++;
    checkReady("sweep_ready_cycle33", 1'b1);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      checkReads($sformatf("sweep_zero_%0d", i), 32'h0, 32'h0);
    end
  endtask

  task automatic test_write_read();
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
    checkReads("write_r5", 32'hDEADBEEF, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd6, 5'd5);
    checkReads("swap_r5", 32'h0, 32'hDEADBEEF);
  endtask

  task automatic test_reg_zero();
    applyStimulus(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    checkReads("r0_same_cycle", 32'h0, 32'h0);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    checkReads("r0_next_cycle", 32'h0, 32'h0);
    step();
    checkReads("r0_later", 32'h0, 32'h0);
  endtask

  task automatic test_same_cycle();
    applyStimulus(1'b1, 5'd7, 32'h00000001, 5'd0, 5'd0);
    step();
    applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7);
`ifdef REGFILE_BYPASS_EN
    checkReads("r7_same_cycle", 32'hA5A5A5A5, 32'hA5A5A5A5);
`else
    checkReads("r7_same_cycle", 32'h00000001, 32'h00000001);
`endif
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    checkReads("r7_next_cycle", 32'hA5A5A5A5, 32'hA5A5A5A5);
  endtask

  task automatic test_clear_write_ignored();
    rst = 1'b1;
    step();
    rst = 1'b0;
    applyStimulus(1'b1, 5'd3, 32'hFFFFFFFF, 5'd5, 5'd7);
    checkReads("clear_reads_forced", 32'h0, 32'h0);
    for (int i = 1; i <= 32; i++) begin
      if (i == 32) begin
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
      end else begin
        step();
      end
    end
    checkReady("clear_write_ready", 1'b1);
    checkReads("clear_write_r3", 32'h0, 32'h0);
    step();
    checkReads("clear_write_r3_later", 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid_sweep();
    bit fillOk;
    bit lowOk;
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 32'(i), 5'd0, 5'd0);
      step();
    end
    fillOk = 1'b1;
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
      if (bus.read_data_a !== 32'(i) || bus.read_data_b !== 32'(32 - i)) begin
        fillOk = 1'b0;
        $display("[TB] FAIL fill_%0d: a=%h b=%h expected a=%h b=%h",
                 i, bus.read_data_a, bus.read_data_b, 32'(i), 32'(32 - i));
      end
    end
    checkCount++;
    if (fillOk) passCount++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    checkReady("mid_sweep_before_pulse", 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    lowOk = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      if (bus.ready !== 1'b0) begin
        lowOk = 1'b0;
        $display("[TB] FAIL restart_low: ready=%b expected 0 at cycle %0d", bus.ready, i);
      end
      step();
    end
    checkCount++;
    if (lowOk) passCount++;
    checkReady("restart_ready", 1'b1);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      checkReads($sformatf("restart_zero_%0d", i), 32'h0, 32'h0);
    end
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst        = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    step();
    test_reset();
    test_clear_sweep();
    test_write_read();
    test_reg_zero();
    test_same_cycle();
    test_clear_write_ignored();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
